// File: rtl/router_pkg.sv
// Shared constants, state encoding and header packing for the router packet transmitter.
package router_pkg;

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned LEN_WIDTH  = 6;
   localparam int unsigned ADDR_WIDTH = 2;

   // Port 3 does not exist on the 1x3 router.
   localparam logic [ADDR_WIDTH-1:0] ILLEGAL_ADDR = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StHeader,
      StPayload,
      StParity,
      StErrChk
   } tx_state_e;

   function automatic logic [DATA_WIDTH-1:0] pack_header(input logic [LEN_WIDTH-1:0]  len,
                                                         input logic [ADDR_WIDTH-1:0] addr);
      return {len, addr};
   endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Command, host payload and router-side signals of the packet transmitter.
interface router_pkt_tx_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LEN_WIDTH  = 6
) ();

   logic                                cmd_valid;
   logic                                cmd_ready;
   logic [router_pkg::ADDR_WIDTH-1:0]   cmd_addr;
   logic [LEN_WIDTH-1:0]                cmd_len;
   logic                                cmd_bad_parity;
   logic                                cmd_reject;
   logic [DATA_WIDTH-1:0]               pl_data;
   logic                                pl_valid;
   logic                                pl_ready;
   logic                                busy;
   logic                                err;
   logic [DATA_WIDTH-1:0]               data_out;
   logic                                pkt_valid;
   logic                                tx_done;
   logic                                tx_err;

   // master is the transmitter, slave is the host/router environment.
   modport master (
      input  cmd_valid, cmd_addr, cmd_len, cmd_bad_parity, pl_data, pl_valid, busy, err,
      output cmd_ready, cmd_reject, pl_ready, data_out, pkt_valid, tx_done, tx_err
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len, cmd_bad_parity, pl_data, pl_valid, busy, err,
      input  cmd_ready, cmd_reject, pl_ready, data_out, pkt_valid, tx_done, tx_err
   );

endinterface

// File: rtl/router_tx_buf.sv
// Payload buffer: register array with synchronous write and combinational read.
module router_tx_buf #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a payload, then sends header, payload and parity
// under busy back-pressure and reports the router's err flag per packet.
module router_pkt_tx #(
   parameter int unsigned DATA_WIDTH = router_pkg::DATA_WIDTH,
   parameter int unsigned LEN_WIDTH  = router_pkg::LEN_WIDTH,
   parameter int unsigned ERR_WINDOW = 3
) (
   input logic             clk,
   input logic             resetn,
   router_pkt_tx_if.master bus
);

   import router_pkg::*;

   localparam int unsigned WinW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
   localparam logic [WinW-1:0]      WinLast = WinW'(ERR_WINDOW - 1);
   localparam logic [LEN_WIDTH-1:0] LenOne  = 1;

   tx_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic                  bad_q, bad_d;
   logic [LEN_WIDTH-1:0]  wr_idx_q, wr_idx_d;
   logic [LEN_WIDTH-1:0]  rd_idx_q, rd_idx_d;
   logic [DATA_WIDTH-1:0] parity_q, parity_d;
   logic [WinW-1:0]       win_q, win_d;
   logic                  flag_q, flag_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  pkt_valid_q, pkt_valid_d;
   logic                  tx_done_q, tx_done_d;
   logic                  tx_err_q, tx_err_d;
   logic                  cmd_reject_q, cmd_reject_d;

   logic                  wr_en;
   logic [LEN_WIDTH-1:0]  rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;

   router_tx_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (LEN_WIDTH)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_idx_q),
      .wr_data (bus.pl_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      bad_d        = bad_q;
      wr_idx_d     = wr_idx_q;
      rd_idx_d     = rd_idx_q;
      parity_d     = parity_q;
      win_d        = win_q;
      flag_d       = flag_q;
      data_out_d   = data_out_q;
      pkt_valid_d  = pkt_valid_q;
      tx_done_d    = 1'b0;
      tx_err_d     = 1'b0;
      cmd_reject_d = 1'b0;
      wr_en        = 1'b0;
      rd_addr      = '0;

      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_addr == ILLEGAL_ADDR || bus.cmd_len == '0) begin
                  cmd_reject_d = 1'b1;
               end else begin
                  addr_d   = bus.cmd_addr;
                  len_d    = bus.cmd_len;
                  bad_d    = bus.cmd_bad_parity;
                  parity_d = pack_header(bus.cmd_len, bus.cmd_addr);
                  wr_idx_d = '0;
                  state_d  = StLoad;
               end
            end
         end
         StLoad: begin
            if (bus.pl_valid) begin
               wr_en    = 1'b1;
               parity_d = parity_q ^ bus.pl_data;
               wr_idx_d = wr_idx_q + LenOne;
               if (wr_idx_q == len_q - LenOne) begin
                  data_out_d  = pack_header(len_q, addr_q);
                  pkt_valid_d = 1'b1;
                  state_d     = StHeader;
               end
            end
         end
         StHeader: begin
            rd_addr = '0;
            if (!bus.busy) begin
               data_out_d = rd_data;
               rd_idx_d   = '0;
               state_d    = StPayload;
            end
         end
         StPayload: begin
            // Look one byte ahead so the next payload byte is ready at acceptance.
            rd_addr = rd_idx_q + LenOne;
            if (!bus.busy) begin
               if (rd_idx_q != len_q - LenOne) begin
                  data_out_d = rd_data;
                  rd_idx_d   = rd_idx_q + LenOne;
               end else begin
                  data_out_d  = parity_q ^ {{(DATA_WIDTH-1){1'b0}}, bad_q};
                  pkt_valid_d = 1'b0;
                  state_d     = StParity;
               end
            end
         end
         StParity: begin
            if (!bus.busy) begin
               data_out_d = '0;
               win_d      = '0;
               flag_d     = 1'b0;
               state_d    = StErrChk;
            end
         end
         StErrChk: begin
            flag_d = flag_q | bus.err;
            win_d  = win_q + 1'b1;
            if (win_q == WinLast) begin
               tx_done_d = 1'b1;
               tx_err_d  = flag_q | bus.err;
               state_d   = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         len_q        <= '0;
         bad_q        <= 1'b0;
         wr_idx_q     <= '0;
         rd_idx_q     <= '0;
         parity_q     <= '0;
         win_q        <= '0;
         flag_q       <= 1'b0;
         data_out_q   <= '0;
         pkt_valid_q  <= 1'b0;
         tx_done_q    <= 1'b0;
         tx_err_q     <= 1'b0;
         cmd_reject_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         bad_q        <= bad_d;
         wr_idx_q     <= wr_idx_d;
         rd_idx_q     <= rd_idx_d;
         parity_q     <= parity_d;
         win_q        <= win_d;
         flag_q       <= flag_d;
         data_out_q   <= data_out_d;
         pkt_valid_q  <= pkt_valid_d;
         tx_done_q    <= tx_done_d;
         tx_err_q     <= tx_err_d;
         cmd_reject_q <= cmd_reject_d;
      end
   end

   // Gated with resetn so no command is offered while the block is held in reset.
   assign bus.cmd_ready  = resetn && (state_q == StIdle);
   assign bus.pl_ready   = (state_q == StLoad);
   assign bus.data_out   = data_out_q;
   assign bus.pkt_valid  = pkt_valid_q;
   assign bus.tx_done    = tx_done_q;
   assign bus.tx_err     = tx_err_q;
   assign bus.cmd_reject = cmd_reject_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: basic, back-pressure, illegal, error-injection,
// full-buffer and mid-packet-reset scenarios with hand-computed bytes.
module tb_router_pkt_tx;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] tx_bytes[$];
   logic [7:0] rx_data[$];
   logic       rx_valid[$];

   router_pkt_tx_if #(.DATA_WIDTH(8), .LEN_WIDTH(6)) bus ();

   router_pkt_tx #(
      .DATA_WIDTH (8),
      .LEN_WIDTH  (6),
      .ERR_WINDOW (3)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic idle_inputs();
      bus.cmd_valid      = 1'b0;
      bus.cmd_addr       = 2'b00;
      bus.cmd_len        = 6'd0;
      bus.cmd_bad_parity = 1'b0;
      bus.pl_data        = 8'h00;
      bus.pl_valid       = 1'b0;
      bus.busy           = 1'b0;
      bus.err            = 1'b0;
   endtask

   // All tasks start and end at a falling edge.
   task automatic send_cmd(input logic [1:0] addr, input logic [5:0] len, input logic bad);
      check("cmd_ready_idle", bus.cmd_ready, 1);
      bus.cmd_valid      = 1'b1;
      bus.cmd_addr       = addr;
      bus.cmd_len        = len;
      bus.cmd_bad_parity = bad;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("pkt_valid_in_load", bus.pkt_valid, 0);
   endtask

   task automatic load(input bit gaps);
      for (int i = 0; i < tx_bytes.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               bus.pl_valid = 1'b0;
               @(negedge clk);
            end
         end
         check("pl_ready_load", bus.pl_ready, 1);
         bus.pl_valid = 1'b1;
         bus.pl_data  = tx_bytes[i];
         @(negedge clk);
      end
      bus.pl_valid = 1'b0;
   endtask

   // Acts as the router: records each accepted byte, stalls stall_n cycles at index stall_idx.
   task automatic collect(input int stall_idx, input int stall_n, input logic err_lvl);
      int   stalls = 0;
      int   cyc    = 0;
      bit   done   = 0;
      logic [7:0] cur;
      logic       curv;
      rx_data.delete();
      rx_valid.delete();
      bus.err = err_lvl;
      while (!done && cyc < 300) begin
         cur  = bus.data_out;
         curv = bus.pkt_valid;
         if (rx_data.size() == stall_idx && stalls < stall_n) begin
            bus.busy = 1'b1;
            stalls++;
         end else begin
            bus.busy = 1'b0;
            rx_data.push_back(cur);
            rx_valid.push_back(curv);
            if (!curv) done = 1;
         end
         @(negedge clk);
         cyc++;
         if (bus.busy) check("hold_under_busy", {bus.pkt_valid, bus.data_out}, {curv, cur});
      end
      bus.busy = 1'b0;
      if (!done) check("collect_timeout", 0, 1);
   endtask

   task automatic finish_pkt(input bit drive_err, input logic exp_err);
      int n = 0;
      check("dout_after_parity", bus.data_out, 0);
      while (!bus.tx_done && n < 10) begin
         bus.err = (drive_err && n == 1);
         @(negedge clk);
         n++;
      end
      bus.err = 1'b0;
      check("done_latency", n, 3);
      check("tx_err", bus.tx_err, exp_err);
      @(negedge clk);
      check("done_one_cycle", bus.tx_done, 0);
   endtask

   task automatic run_packet(input logic [1:0] addr, input logic [5:0] len, input logic bad,
                             input int stall_idx, input int stall_n, input logic err_payload,
                             input bit drive_err, input bit gaps,
                             input logic [7:0] exp_hdr, input logic [7:0] exp_par);
      logic [7:0] exp_b;
      int         n;
      send_cmd(addr, len, bad);
      load(gaps);
      collect(stall_idx, stall_n, err_payload);
      check("rx_count", rx_data.size(), len + 2);
      n = (rx_data.size() < len + 2) ? rx_data.size() : len + 2;
      for (int i = 0; i < n; i++) begin
         exp_b = (i == 0) ? exp_hdr : (i <= len) ? tx_bytes[i-1] : exp_par;
         check($sformatf("byte%0d", i), rx_data[i], exp_b);
         check($sformatf("valid%0d", i), rx_valid[i], (i <= len));
      end
      finish_pkt(drive_err, drive_err);
   endtask

   task automatic illegal(input logic [1:0] addr, input logic [5:0] len);
      check("cmd_ready_idle", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      bus.pl_valid  = 1'b1;
      bus.pl_data   = 8'h55;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("reject_pulse", bus.cmd_reject, 1);
      check("reject_pl_ready", bus.pl_ready, 0);
      @(negedge clk);
      check("reject_one_cycle", bus.cmd_reject, 0);
      check("reject_pl_ready2", bus.pl_ready, 0);
      check("reject_stay_idle", bus.cmd_ready, 1);
      bus.pl_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("reject_no_pkt", bus.pkt_valid, 0);
   endtask

   initial begin
      logic [7:0] par;
      bit         seen_done;
      idle_inputs();
      repeat (2) @(negedge clk);
      check("rst_data_out", bus.data_out, 0);
      check("rst_pkt_valid", bus.pkt_valid, 0);
      check("rst_tx_done", bus.tx_done, 0);
      check("rst_tx_err", bus.tx_err, 0);
      check("rst_cmd_reject", bus.cmd_reject, 0);
      check("rst_pl_ready", bus.pl_ready, 0);
      check("rst_cmd_ready", bus.cmd_ready, 0);
      resetn = 1'b1;
      @(negedge clk);

      // Basic packet: 0D A1 B2 C3 | DD.
      tx_bytes = '{8'hA1, 8'hB2, 8'hC3};
      run_packet(2'b01, 6'd3, 1'b0, -1, 0, 1'b0, 0, 0, 8'h0D, 8'hDD);

      // B2 stalled two cycles; err high before ERR_CHK must be ignored.
      run_packet(2'b01, 6'd3, 1'b0, 2, 2, 1'b1, 0, 0, 8'h0D, 8'hDD);

      illegal(2'b11, 6'd5);
      illegal(2'b00, 6'd0);

      // Inverted parity bit 0, stall on the last payload byte, err in 2nd ERR_CHK cycle.
      run_packet(2'b01, 6'd3, 1'b1, 3, 1, 1'b0, 1, 0, 8'h0D, 8'hDC);

      // Full buffer with random load gaps.
      tx_bytes.delete();
      par = 8'hFE;
      for (int i = 0; i < 63; i++) begin
         tx_bytes.push_back(8'($urandom));
         par ^= tx_bytes[i];
      end
      run_packet(2'b10, 6'd63, 1'b0, -1, 0, 1'b0, 0, 1, 8'hFE, par);

      // Reset while the second payload byte is on the wire.
      tx_bytes = '{8'hA1, 8'hB2, 8'hC3};
      send_cmd(2'b01, 6'd3, 1'b0);
      load(0);
      @(negedge clk);
      @(negedge clk);
      check("mid_b2", bus.data_out, 8'hB2);
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_data_out", bus.data_out, 0);
      check("mid_rst_pkt_valid", bus.pkt_valid, 0);
      check("mid_rst_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
      resetn = 1'b1;
      seen_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.tx_done || bus.pkt_valid) seen_done = 1;
      end
      check("mid_rst_no_done", seen_done, 0);
      run_packet(2'b01, 6'd3, 1'b0, -1, 0, 1'b0, 0, 0, 8'h0D, 8'hDD);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
